fft_mul_sched: RTL and testbench
================================

# fft_mul_sched

Round-robin scheduler that shares one pipelined FP32 mantissa/multiplier unit among `N_REQ` requesters, such as the butterfly twiddle-multiply ports of the 8-point FFT. It grants at most one operand pair per cycle and registers it into the shared multiplier. A tag pipeline tracks each issued operation, and the block returns each product to its originating requester. A hold input drains the pipeline cleanly at FFT stage boundaries.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: operand/result width (FP32).
- `MUL_LAT`, 3: fixed multiplier latency in cycles, ≥1, from `o_mul_valid` to the matching `i_mul_result`.
- Derived localparams:
  - `ID_W` = max(1, $clog2(N_REQ)).
  - `CNT_W` = $clog2(MUL_LAT+3).
- `i_clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `i_rst`  in  1  synchronous active-high reset.
- `i_hold`  in  1  stop granting new requests; in-flight ops complete.
- `i_req_valid`  in  N_REQ  per-requester operand valid.
- `i_req_a`  in  N_REQ*DATA_W  operand A, requester k at bits [k*DATA_W +: DATA_W].
- `i_req_b`  in  N_REQ*DATA_W  operand B, same packing as `i_req_a`.
- `o_req_ready`  out  N_REQ  one-hot grant; accept occurs when valid&ready.
- `o_mul_valid`  out  1  operands on `o_mul_a`/`o_mul_b` are valid this cycle.
- `o_mul_a`, `o_mul_b`  out  DATA_W  registered operands to the shared multiplier.
- `i_mul_result`  in  DATA_W  multiplier product.
- `o_res_valid`  out  N_REQ  one-hot result strobe.
- `o_res_data`  out  DATA_W  registered product.
- `o_res_id`  out  ID_W  requester index of the result.
- `o_inflight`  out  CNT_W  number of accepted ops not yet returned.
- `o_busy`  out  1  `o_inflight` != 0.
- `o_halted`  out  1  state is HALT.

## Operation
- Arbitration:
  - Round-robin. Priority starts at `rr_ptr`+1 (mod N_REQ).
  - `o_req_ready` is the combinational one-hot grant from `i_req_valid`. It is all-zero in HALT or DRAIN, and all-zero whenever `i_hold`=1.
  - `rr_ptr` updates to the granted index only on accept.
  - Reset value of `rr_ptr` is N_REQ-1, so requester 0 has first priority.
- Issue:
  - On accept, the selected A/B are registered into `o_mul_a`/`o_mul_b` and `o_mul_valid`=1 the next cycle.
  - `o_mul_valid`=0 on cycles with no accept. The operand registers hold their last value.
- Tag pipeline:
  - Shift register of {valid, id}, depth MUL_LAT+1, loaded at accept.
  - At the tail, when the tag valid bit is set, `i_mul_result` is captured into `o_res_data`, `o_res_id` is set to the tag id, and `o_res_valid` is one-hot of id for exactly one cycle.
- Backpressure: none on results. Requesters must sink `o_res_valid` unconditionally.
- `o_inflight`:
  - +1 on accept, −1 on result strobe, net 0 when both happen in the same cycle.
  - Maximum value is MUL_LAT+2. It never wraps.
- FSM states:
  - IDLE: `o_inflight`=0 and not holding.
  - RUN: accepting.
  - DRAIN: hold requested and `o_inflight`>0.
  - HALT: hold and `o_inflight`=0.
- FSM transitions:
  - IDLE→RUN on accept.
  - RUN→IDLE when `o_inflight` reaches 0 with no accept.
  - IDLE/RUN→DRAIN when `i_hold`=1 and `o_inflight`>0.
  - IDLE/RUN→HALT when `i_hold`=1 and `o_inflight`=0.
  - DRAIN→HALT when the last result strobes.
  - HALT→IDLE when `i_hold`=0.
  - DRAIN→RUN when `i_hold` drops before the drain completes.
- Reset values:
  - All `o_*` outputs are 0, except `o_req_ready`, which follows arbitration.
  - State = IDLE.
  - Tag pipeline is cleared.
- Reset mid-operation: in-flight ops are dropped. No `o_res_valid` is produced for them, even though the multiplier still outputs data.

## Timing
- Latency: accept at cycle t → `o_mul_valid` at t+1 → `i_mul_result` sampled at t+1+MUL_LAT → `o_res_valid` at t+2+MUL_LAT.
- Throughput is one op per cycle with no bubbles while requests are pending and `i_hold`=0.
- Simultaneous `i_hold` rise and valid request: no accept that cycle.
- Results return in issue order.

## Structure
- Shared package `fft_pkg`:
  - FSM state typedef `sched_state_e` {IDLE, RUN, DRAIN, HALT}.
  - Tag struct {logic vld; logic [ID_W-1:0] id}.
- One sub-module, `rr_arbiter`: parameterised N, request vector in, one-hot grant out, pointer update on accept. Reusable elsewhere in the FFT controller.
- The multiplier itself stays outside this block.

## Test plan
- Single op, MUL_LAT=3:
  - Stimulus: requester 2 sends A=0x3FC00000 (1.5), B=0x40000000 (2.0) at t=5; bench model returns 0x40400000.
  - Response: `o_mul_valid` at t=6; `o_res_valid`=4'b0100, `o_res_id`=2, `o_res_data`=0x40400000 at t=10.
- All four requesters hold valid for 8 cycles:
  - Response: grant order 0,1,2,3,0,1,2,3; results in that order on consecutive cycles; `o_inflight` peaks at MUL_LAT+2=5 (accepts through t+4, first result at t+5).
- Hold during a burst:
  - Stimulus: assert `i_hold` after 2 accepts.
  - Response: `o_req_ready`=0 the same cycle; state DRAIN; both results still return; `o_halted`=1 the cycle after the last result. Releasing hold returns to IDLE, then resumes arbitration from `rr_ptr`+1.
- Reset mid-flight:
  - Stimulus: `i_rst` for 1 cycle with 3 ops in flight.
  - Response: no `o_res_valid` for them; `o_inflight`=0; first grant after reset goes to requester 0.
- Simultaneous accept and result strobe: `o_inflight` is unchanged that cycle.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types for the FFT multiplier scheduler
package fft_pkg;

  // Widest requester id supported (N_REQ up to 8); blocks truncate to their own ID_W.
  localparam int TAG_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } sched_state_e;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves on accept
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req,
  input  logic           i_en,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_id,
  output logic           o_accept
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int             idx_wide;
    logic [IDW-1:0] idx;
    logic           found;
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx_wide   = 0;
    idx        = '0;
    for (int i = 1; i <= N; i++) begin
      idx_wide = (int'(ptr_q) + i) % N;
      idx      = IDW'(idx_wide);
      if (i_en && !found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_grant_id   = idx;
        found        = 1'b1;
      end
    end
    o_accept = found;
    ptr_d    = found ? o_grant_id : ptr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= IDW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fft_mul_sched.sv
// rtl/fft_mul_sched.sv - shares one pipelined multiplier among N_REQ requesters
module fft_mul_sched
  import fft_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  DATA_W  = 32,
  parameter int  MUL_LAT = 3,
  localparam int ID_W    = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  localparam int CNT_W   = $clog2(MUL_LAT + 3)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_hold,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_mul_valid,
  output logic [DATA_W-1:0]       o_mul_a,
  output logic [DATA_W-1:0]       o_mul_b,
  input  logic [DATA_W-1:0]       i_mul_result,
  output logic [N_REQ-1:0]        o_res_valid,
  output logic [DATA_W-1:0]       o_res_data,
  output logic [ID_W-1:0]         o_res_id,
  output logic [CNT_W-1:0]        o_inflight,
  output logic                    o_busy,
  output logic                    o_halted
);

  sched_state_e             state_q;
  logic                     halted_q;
  logic                     arb_en;
  logic                     accept;
  logic [N_REQ-1:0]         grant;
  logic [ID_W-1:0]          grant_id;
  logic                     mul_valid_q;
  logic [DATA_W-1:0]        mul_a_q;
  logic [DATA_W-1:0]        mul_b_q;
  tag_t [MUL_LAT:0]         tag_q;
  tag_t                     tag_in;
  tag_t                     tail;
  logic [N_REQ-1:0]         res_valid_q;
  logic [DATA_W-1:0]        res_data_q;
  logic [ID_W-1:0]          res_id_q;
  logic [CNT_W-1:0]         inflight_q;
  logic [CNT_W-1:0]         inflight_d;
  logic                     busy_q;
  logic                     strobe;

  assign arb_en = !i_hold && ((state_q == IDLE) || (state_q == RUN));

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req_valid),
    .i_en       (arb_en),
    .o_grant    (grant),
    .o_grant_id (grant_id),
    .o_accept   (accept)
  );

  assign o_req_ready = grant;
  assign tail        = tag_q[MUL_LAT];
  assign strobe      = |res_valid_q;

  always_comb begin
    tag_in     = '0;
    tag_in.vld = accept;
    tag_in.id  = TAG_ID_W'(grant_id);
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !strobe) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!accept && strobe) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      mul_valid_q <= accept;
      if (accept) begin
        mul_a_q <= i_req_a[grant_id*DATA_W +: DATA_W];
        mul_b_q <= i_req_b[grant_id*DATA_W +: DATA_W];
      end
      tag_q <= {tag_q[MUL_LAT-1:0], tag_in};
      // The tail tag lines up with the cycle the multiplier presents this op's product.
      if (tail.vld) begin
        res_valid_q <= N_REQ'(1) << tail.id;
        res_data_q  <= i_mul_result;
        res_id_q    <= ID_W'(tail.id);
      end else begin
        res_valid_q <= '0;
      end
      inflight_q <= inflight_d;
      busy_q     <= (inflight_d != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (i_hold) begin
            state_q  <= (inflight_d != '0) ? DRAIN : HALT;
            halted_q <= (inflight_d == '0);
          end else if (accept) begin
            state_q <= RUN;
          end else if (inflight_d == '0) begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (!i_hold) begin
            state_q <= RUN;
          end else if (inflight_d == '0) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (!i_hold) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_mul_valid = mul_valid_q;
  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_res_id    = res_id_q;
  assign o_inflight  = inflight_q;
  assign o_busy      = busy_q;
  assign o_halted    = halted_q;

endmodule

// File: tb/tb_fft_mul_sched.sv
// tb/tb_fft_mul_sched.sv - directed self-checking bench for fft_mul_sched
module tb_fft_mul_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int IDW = 2;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           hold;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           mul_valid;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [W-1:0]   mul_result;
  logic [N-1:0]   res_valid;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic [CW-1:0]  inflight;
  logic           busy;
  logic           halted;

  int ntests = 0;
  int nfail  = 0;

  logic [W-1:0] b_tab [N]  = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000};
  logic [W-1:0] p_tab [N]  = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40C0_0000};
  logic [W-1:0] mul_pipe [LAT];

  always #5 clk = ~clk;

  fft_mul_sched #(
    .N_REQ   (N),
    .DATA_W  (W),
    .MUL_LAT (LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hold       (hold),
    .i_req_valid  (req_valid),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_req_ready  (req_ready),
    .o_mul_valid  (mul_valid),
    .o_mul_a      (mul_a),
    .o_mul_b      (mul_b),
    .i_mul_result (mul_result),
    .o_res_valid  (res_valid),
    .o_res_data   (res_data),
    .o_res_id     (res_id),
    .o_inflight   (inflight),
    .o_busy       (busy),
    .o_halted     (halted)
  );

  // Truncating FP32 multiply for normal operands; stands in for the shared unit.
  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [47:0] p;
    int          e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return {a[31] ^ b[31], 8'(e + 1), p[46:24]};
    return {a[31] ^ b[31], 8'(e), p[45:23]};
  endfunction

  always @(posedge clk) begin
    mul_pipe[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign mul_result = mul_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_table();
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = 32'h4000_0000;
      req_b[k*W +: W] = b_tab[k];
    end
  endtask

  initial begin
    int exp_inf;
    int done;
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_mul_valid", mul_valid, 1'b0);
    chk("rst_mul_a", mul_a, 32'h0);
    chk("rst_res_valid", res_valid, 4'b0000);
    chk("rst_inflight", inflight, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single op from requester 2: 1.5 * 2.0
    req_a[2*W +: W] = 32'h3FC0_0000;
    req_b[2*W +: W] = 32'h4000_0000;
    req_valid = 4'b0100;
    #1 chk("t1_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("t1_mul_valid", mul_valid, 1'b1);
    chk("t1_mul_a", mul_a, 32'h3FC0_0000);
    chk("t1_mul_b", mul_b, 32'h4000_0000);
    chk("t1_inflight", inflight, 3'd1);
    chk("t1_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_mul_valid_off", mul_valid, 1'b0);
    chk("t1_mul_a_hold", mul_a, 32'h3FC0_0000);
    repeat (2) @(negedge clk);
    chk("t1_res_early", res_valid, 4'b0000);
    @(negedge clk);
    chk("t1_res_valid", res_valid, 4'b0100);
    chk("t1_res_id", res_id, 2'd2);
    chk("t1_res_data", res_data, 32'h4040_0000);
    chk("t1_inflight_at_res", inflight, 3'd1);
    @(negedge clk);
    chk("t1_res_off", res_valid, 4'b0000);
    chk("t1_inflight_end", inflight, 3'd0);
    chk("t1_busy_end", busy, 1'b0);

    // Hold after two accepts; pointer is at 2 so requester 3 goes first
    load_table();
    req_valid = 4'b1111;
    #1 chk("h_ready0", req_ready, 4'b1000);
    @(negedge clk);
    #1 chk("h_ready1", req_ready, 4'b0001);
    @(negedge clk);
    hold = 1'b1;
    #1 chk("h_ready_hold", req_ready, 4'b0000);
    chk("h_inflight2", inflight, 3'd2);
    @(negedge clk);
    chk("h_drain_halted", halted, 1'b0);
    chk("h_drain_busy", busy, 1'b1);
    chk("h_drain_ready", req_ready, 4'b0000);
    repeat (2) @(negedge clk);
    chk("h_res0_valid", res_valid, 4'b1000);
    chk("h_res0_id", res_id, 2'd3);
    chk("h_res0_data", res_data, 32'h40C0_0000);
    @(negedge clk);
    chk("h_res1_valid", res_valid, 4'b0001);
    chk("h_res1_data", res_data, 32'h4000_0000);
    chk("h_res1_halted", halted, 1'b0);
    @(negedge clk);
    chk("h_halted", halted, 1'b1);
    chk("h_halt_inflight", inflight, 3'd0);
    chk("h_halt_busy", busy, 1'b0);
    @(negedge clk);
    hold = 1'b0;
    #1 chk("h_release_ready", req_ready, 4'b0000);
    @(negedge clk);
    #1 chk("h_resume_ready", req_ready, 4'b0010);
    chk("h_resume_halted", halted, 1'b0);
    @(negedge clk);
    #1 chk("h_resume_ready2", req_ready, 4'b0100);
    @(negedge clk);
    #1 chk("h_resume_ready3", req_ready, 4'b1000);

    // Reset with three ops in flight
    @(negedge clk);
    chk("r_inflight3", inflight, 3'd3);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("r_inflight0", inflight, 3'd0);
    chk("r_busy", busy, 1'b0);
    chk("r_mul_valid", mul_valid, 1'b0);

    // Burst of 8 cycles, all requesters valid; first grant after reset is 0
    load_table();
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (i < 8) chk($sformatf("b_ready%0d", i), req_ready, 4'b0001 << (i % 4));
      done    = (i > 5) ? i - 5 : 0;
      exp_inf = ((i < 8) ? i : 8) - ((done > 8) ? 8 : done);
      chk($sformatf("b_inflight%0d", i), inflight, 64'(exp_inf));
      if (i >= 5 && i < 13) begin
        chk($sformatf("b_res_valid%0d", i), res_valid, 4'b0001 << ((i - 5) % 4));
        chk($sformatf("b_res_id%0d", i), res_id, 64'((i - 5) % 4));
        chk($sformatf("b_res_data%0d", i), res_data, p_tab[(i - 5) % 4]);
      end else begin
        chk($sformatf("b_res_none%0d", i), res_valid, 4'b0000);
      end
      if (i == 1) begin
        chk("b_mul_valid", mul_valid, 1'b1);
        chk("b_mul_b", mul_b, 32'h3F80_0000);
      end
    end
    chk("b_busy_end", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
